// File: rtl/fmul32_arb.sv
// fmul32_arb: shares one pipelined FMUL32 core between NREQ requesters.
// A round-robin grant issues at most one operand pair per cycle. A tag pipe
// that runs alongside the core remembers which requester owns each op, so
// the result and its flags go back to that requester.
// Optional build macro FMUL_ARB_PRIO_EN: requester 0 gets strict priority and
// the round-robin pointer only ranges over requesters 1..NREQ-1.
module fmul32_arb #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_res,
    output logic [2:0]           rsp_flags,
    output logic                 core_valid,
    output logic [31:0]          core_a,
    output logic [31:0]          core_b,
    input  logic [31:0]          core_res,
    input  logic [2:0]           core_flags
);

    localparam int TAGW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef FMUL_ARB_PRIO_EN
    localparam logic [TAGW-1:0] RR_RESET = TAGW'(1);
`else
    localparam logic [TAGW-1:0] RR_RESET = '0;
`endif

    logic [TAGW-1:0] rr_ptr;
    logic [TAGW-1:0] rr_next;
    logic [TAGW-1:0] grant_idx;
    logic            found;
    logic            xfer;
    int              scan_idx;
    logic [31:0]     sel_a;
    logic [31:0]     sel_b;
    logic [TAGW-1:0] issue_tag;

    logic [LATENCY:1] stage_vld;
    logic [TAGW-1:0]  stage_tag [1:LATENCY];

    // Pick the first requesting index at or after rr_ptr, wrapping around
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = 0;
`ifdef FMUL_ARB_PRIO_EN
        if (req_valid[0]) begin
            found = 1'b1;
        end
        for (int k = 0; k < NREQ - 1; k++) begin
            scan_idx = 1 + ((int'(rr_ptr) - 1 + k) % (NREQ - 1));
            if (!found && req_valid[TAGW'(scan_idx)]) begin
                found     = 1'b1;
                grant_idx = TAGW'(scan_idx);
            end
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[TAGW'(scan_idx)]) begin
                found     = 1'b1;
                grant_idx = TAGW'(scan_idx);
            end
        end
`endif
    end

    // Grant is suppressed during flush and reset; a grant is always a transfer
    assign xfer      = found && !flush && !rst;
    assign req_ready = xfer ? (NREQ'(1) << grant_idx) : '0;

    // Operand mux for the granted requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == TAGW'(i)) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
            end
        end
    end

    // Pointer advance: one past the winner; a priority grant to 0 leaves it alone
    always_comb begin
`ifdef FMUL_ARB_PRIO_EN
        if (grant_idx == '0) begin
            rr_next = rr_ptr;
        end else if (grant_idx == TAGW'(NREQ - 1)) begin
            rr_next = TAGW'(1);
        end else begin
            rr_next = grant_idx + TAGW'(1);
        end
`else
        if (grant_idx == TAGW'(NREQ - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = grant_idx + TAGW'(1);
        end
`endif
    end

    // Issue register: operands and owner tag launched into the core
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_valid <= 1'b0;
            core_a     <= '0;
            core_b     <= '0;
            issue_tag  <= '0;
            rr_ptr     <= RR_RESET;
        end else begin
            core_valid <= xfer;
            if (xfer) begin
                core_a    <= sel_a;
                core_b    <= sel_b;
                issue_tag <= grant_idx;
                rr_ptr    <= rr_next;
            end
        end
    end

    // Tag pipe: stage LATENCY lines up with core_res; flush empties it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_vld <= '0;
            for (int k = 1; k <= LATENCY; k++) begin
                stage_tag[k] <= '0;
            end
        end else begin
            stage_vld[1] <= core_valid && !flush;
            stage_tag[1] <= issue_tag;
            for (int k = 2; k <= LATENCY; k++) begin
                stage_vld[k] <= stage_vld[k-1] && !flush;
                stage_tag[k] <= stage_tag[k-1];
            end
        end
    end

    // Response register: route the core result to its owner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_res   <= '0;
            rsp_flags <= '0;
        end else if (flush || !stage_vld[LATENCY]) begin
            rsp_valid <= '0;
        end else begin
            rsp_valid <= NREQ'(1) << stage_tag[LATENCY];
            rsp_res   <= core_res;
            rsp_flags <= core_flags;
        end
    end

endmodule

// File: tb/tb_fmul32_arb.sv
// Testbench for fmul32_arb: table vectors, hand-written arbitration, flush
// and reset sequences, then random traffic against a cycle-level model.
module tb_fmul32_arb;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                flush;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*32-1:0]  req_a;
    logic [NREQ*32-1:0]  req_b;
    logic [NREQ-1:0]     rsp_valid;
    logic [31:0]         rsp_res;
    logic [2:0]          rsp_flags;
    logic                core_valid;
    logic [31:0]         core_a;
    logic [31:0]         core_b;
    logic [31:0]         core_res;
    logic [2:0]          core_flags;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rsp_seen = 0;

    fmul32_arb #(.NREQ(NREQ), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_flags(rsp_flags),
        .core_valid(core_valid), .core_a(core_a), .core_b(core_b),
        .core_res(core_res), .core_flags(core_flags)
    );

    always #5 clk = ~clk;

    // Simple normal-range float multiply (truncating) used as the core stub
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] ma, mb, m;
        logic [22:0] mant;
        int e;
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'd0};
        ma = {24'd0, 1'b1, a[22:0]};
        mb = {24'd0, 1'b1, b[22:0]};
        m  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (m[47]) begin
            mant = m[46:24];
            e    = e + 1;
        end else begin
            mant = m[45:23];
        end
        return {a[31] ^ b[31], e[7:0], mant};
    endfunction

    function automatic logic [2:0] flags_ref(input logic [31:0] a, input logic [31:0] b);
        return a[2:0] ^ b[2:0];
    endfunction

    // Core stub: fixed LAT-cycle pipeline
    logic [31:0] pipe_res [LAT];
    logic [2:0]  pipe_flg [LAT];
    always @(posedge clk) begin
        pipe_res[0] <= fmul_ref(core_a, core_b);
        pipe_flg[0] <= flags_ref(core_a, core_b);
        for (int k = 1; k < LAT; k++) begin
            pipe_res[k] <= pipe_res[k-1];
            pipe_flg[k] <= pipe_flg[k-1];
        end
    end
    assign core_res   = pipe_res[LAT-1];
    assign core_flags = pipe_flg[LAT-1];

    // Reference model state
    int          m_ptr;
    bit          exp_v   [16];
    int          exp_idx [16];
    logic [31:0] exp_res [16];
    logic [2:0]  exp_flg [16];
    bit          prev_cv;
    logic [31:0] prev_a, prev_b;

    function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
`ifdef FMUL_ARB_PRIO_EN
        if (v[0]) return 0;
        for (int k = 0; k < NREQ - 1; k++) begin
            int i;
            i = 1 + ((ptr - 1 + k) % (NREQ - 1));
            if (v[i]) return i;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (ptr + k) % NREQ;
            if (v[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_reset();
`ifdef FMUL_ARB_PRIO_EN
        m_ptr = 1;
`else
        m_ptr = 0;
`endif
        for (int s = 0; s < 16; s++) exp_v[s] = 1'b0;
        prev_cv = 1'b0;
        prev_a  = '0;
        prev_b  = '0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*32-1:0] a,
                        input logic [NREQ*32-1:0] b, input logic fl,
                        output int g, output logic [NREQ-1:0] rdy);
        int slot, due;
        logic [31:0] ga, gb;
        @(negedge clk);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        flush     = fl;
        #1;
        rdy = req_ready;
        g   = fl ? -1 : model_grant(v, m_ptr);
        check("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        check("core_valid", 32'(core_valid), 32'(prev_cv));
        if (prev_cv) begin
            check("core_a", core_a, prev_a);
            check("core_b", core_b, prev_b);
        end
        if (rsp_valid != '0) rsp_seen++;
        slot = cyc % 16;
        check("rsp_valid", 32'(rsp_valid), exp_v[slot] ? (32'd1 << exp_idx[slot]) : 32'd0);
        if (exp_v[slot]) begin
            check("rsp_res", rsp_res, exp_res[slot]);
            check("rsp_flags", 32'(rsp_flags), 32'(exp_flg[slot]));
        end
        exp_v[slot] = 1'b0;
        if (fl) begin
            for (int s = 0; s < 16; s++) exp_v[s] = 1'b0;
        end
        prev_cv = (g >= 0);
        if (g >= 0) begin
            ga = a[32*g +: 32];
            gb = b[32*g +: 32];
            prev_a = ga;
            prev_b = gb;
            due = (cyc + LAT + 2) % 16;
            exp_v[due]   = 1'b1;
            exp_idx[due] = g;
            exp_res[due] = fmul_ref(ga, gb);
            exp_flg[due] = flags_ref(ga, gb);
`ifdef FMUL_ARB_PRIO_EN
            if (g != 0) m_ptr = (g == NREQ - 1) ? 1 : g + 1;
`else
            m_ptr = (g + 1) % NREQ;
`endif
        end
        @(posedge clk);
        cyc++;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(70, 180));
        return r;
    endfunction

    typedef struct {
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flg;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int g;
        logic [NREQ-1:0] rdy;
        logic [NREQ*32-1:0] va, vb;
        logic [NREQ-1:0] v;
        int exp_seq [8];
        int seen0;
        logic [NREQ-1:0] hold_v;
        logic [NREQ*32-1:0] hold_a, hold_b;
        logic fl;

        vecs[0] = '{0, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000};
        vecs[1] = '{2, 32'h3F800002, 32'h40000000, 32'h40000002, 3'b010};
        vecs[2] = '{1, 32'hBF800000, 32'h40A00000, 32'hC0A00000, 3'b000};
        vecs[3] = '{3, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000};
        vecs[4] = '{0, 32'h41200000, 32'h3DCCCCCD, 32'h3F800000, 3'b101};

        // Reset state, with requests pending to show ready is held low
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_core_valid", 32'(core_valid), 32'd0);
        check("rst_core_a", core_a, 32'd0);
        check("rst_core_b", core_b, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_res", rsp_res, 32'd0);
        check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
        req_valid = '0;
        model_reset();
        #10;
        rst = 1'b0;

        // All requesters held valid: round-robin order, back-to-back results
        va = {32'h40400000, 32'h40000000, 32'h3FC00000, 32'h3F800000};
        vb = {4{32'h40000000}};
`ifdef FMUL_ARB_PRIO_EN
        exp_seq = '{0, 0, 0, 0, 1, 2, 3, 1};
`else
        exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        for (int c = 0; c < 8; c++) begin
`ifdef FMUL_ARB_PRIO_EN
            v = (c < 4) ? 4'b1111 : 4'b1110;
`else
            v = 4'b1111;
`endif
            step(v, va, vb, 1'b0, g, rdy);
            check("rr_order", 32'(rdy), 32'd1 << exp_seq[c]);
        end
        for (int c = 0; c < LAT + 2; c++) step('0, va, vb, 1'b0, g, rdy);

        // Table vectors: one op each, checked at accept+LAT+2
        foreach (vecs[n]) begin
            va = '0;
            vb = '0;
            va[32*vecs[n].idx +: 32] = vecs[n].a;
            vb[32*vecs[n].idx +: 32] = vecs[n].b;
            step(NREQ'(1) << vecs[n].idx, va, vb, 1'b0, g, rdy);
            #1;
            check("tbl_core_valid", 32'(core_valid), 32'd1);
            check("tbl_core_a", core_a, vecs[n].a);
            check("tbl_core_b", core_b, vecs[n].b);
            for (int c = 0; c < LAT + 1; c++) step('0, va, vb, 1'b0, g, rdy);
            #1;
            check("tbl_rsp_valid", 32'(rsp_valid), 32'd1 << vecs[n].idx);
            check("tbl_rsp_res", rsp_res, vecs[n].res);
            check("tbl_rsp_flags", 32'(rsp_flags), 32'(vecs[n].flg));
        end
        for (int c = 0; c < 2; c++) step('0, va, vb, 1'b0, g, rdy);

        // Flush with ops in flight; a pending request is held off, then issues
        va = {32'h40400000, 32'h40000000, 32'h3FC00000, 32'h3F800000};
        vb = {4{32'h40400000}};
        v  = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            step(v, va, vb, 1'b0, g, rdy);
            v = v & ~rdy;
        end
        seen0 = rsp_seen;
        step(4'b1000, va, vb, 1'b1, g, rdy);
        check("flush_no_grant", 32'(rdy), 32'd0);
        step(4'b1000, va, vb, 1'b0, g, rdy);
        check("post_flush_grant", 32'(rdy), 32'b1000);
        for (int c = 0; c < LAT + 3; c++) step('0, va, vb, 1'b0, g, rdy);
        check("flush_rsp_count", 32'(rsp_seen - seen0), 32'd1);

        // Asynchronous reset with a full pipe
        for (int c = 0; c < LAT + 3; c++) step(4'b1111, va, vb, 1'b0, g, rdy);
        #1;
        rst = 1'b1;
        #1;
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_core_valid", 32'(core_valid), 32'd0);
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_core_a", core_a, 32'd0);
        check("arst_rsp_res", rsp_res, 32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        step(4'b1111, va, vb, 1'b0, g, rdy);
        check("arst_ptr_grant", 32'(rdy), 32'b0001);
        seen0 = rsp_seen;
        for (int c = 0; c < LAT + 3; c++) step('0, va, vb, 1'b0, g, rdy);
        check("arst_no_stale", 32'(rsp_seen - seen0), 32'd1);

        // Random traffic with occasional flushes
        hold_v = '0;
        hold_a = '0;
        hold_b = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!hold_v[i] && ($urandom_range(0, 1) == 1)) begin
                    hold_v[i] = 1'b1;
                    hold_a[32*i +: 32] = rand_fp();
                    hold_b[32*i +: 32] = rand_fp();
                end
            end
            fl = ($urandom_range(0, 19) == 0);
            step(hold_v, hold_a, hold_b, fl, g, rdy);
            hold_v = hold_v & ~rdy;
        end
        for (int c = 0; c < LAT + 3; c++) step('0, hold_a, hold_b, 1'b0, g, rdy);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
